// File: rtl/alu_cmd_driver.sv
// Command-side master for a clocked ALU: issues one operation, waits ALU_LAT cycles, returns the
// result and flags with a flag-group consistency check. Optional DIV-by-zero trap: ALU_DRV_DIV0_TRAP_EN.
module alu_cmd_driver #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [3:0]       CMD_FUN,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             Carry_Flag,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             Shift_Flag,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [4:0]       RSP_FLAGS,
  output logic             RSP_ERR,
  output logic             BUSY,
  output logic [CNT_W-1:0] OP_COUNT
);

  localparam int unsigned LatW = 3;
  localparam logic [3:0] FunIllegal = 4'b1111;

  typedef enum logic [1:0] {StIdle, StWait, StCapture, StResp} state_e;

  state_e           state_q, state_d;
  logic [LatW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_fun_q, alu_fun_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic       div0_trap;
  logic       cmd_direct;
  logic [3:0] grp_flags;
  logic [3:0] grp_sel;
  logic       flag_err;

`ifdef ALU_DRV_DIV0_TRAP_EN
  assign div0_trap = (CMD_FUN == 4'b0011) && (CMD_B == '0);
`else
  assign div0_trap = 1'b0;
`endif

  // Commands that never reach the ALU answer immediately with an error response.
  assign cmd_direct = (CMD_FUN == FunIllegal) || div0_trap;

  // Group flags ordered {Shift, CMP, Logic, Arith}; Carry takes no part in the check.
  assign grp_flags = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};

  always_comb begin
    grp_sel = 4'b0000;
    case (alu_fun_q)
      4'h0, 4'h1, 4'h2, 4'h3:             grp_sel = 4'b0001;
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: grp_sel = 4'b0010;
      4'hA, 4'hB, 4'hC:                   grp_sel = 4'b0100;
      4'hD, 4'hE:                         grp_sel = 4'b1000;
      default:                            grp_sel = 4'b0000;
    endcase
  end

  assign flag_err = ~|(grp_flags & grp_sel) | |(grp_flags & ~grp_sel);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          if (cmd_direct) begin
            rsp_data_d  = '0;
            rsp_flags_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = StResp;
          end else begin
            alu_a_d    = CMD_A;
            alu_b_d    = CMD_B;
            alu_fun_d  = CMD_FUN;
            wait_cnt_d = LatW'(ALU_LAT);
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - LatW'(1);
        if (wait_cnt_q == LatW'(1)) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        rsp_data_d  = ALU_OUT;
        rsp_flags_d = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag, Carry_Flag};
        rsp_err_d   = flag_err;
        state_d     = StResp;
      end
      StResp: begin
        if (RSP_READY) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign CMD_READY = (state_q == StIdle);
  assign BUSY      = (state_q != StIdle);
  assign RSP_VALID = (state_q == StResp);
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_FLAGS = rsp_flags_q;
  assign RSP_ERR   = rsp_err_q;
  assign OP_COUNT  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU with flag-fault injection, directed scenarios and a
// randomized stream checked against a transaction-level model of the expected responses.
module tb_alu_cmd_driver;
  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 1;
  localparam int unsigned CW  = 4;

  logic          CLK, RST, CMD_VALID, CMD_READY, RSP_VALID, RSP_READY, RSP_ERR, BUSY;
  logic [3:0]    CMD_FUN, ALU_FUN;
  logic [W-1:0]  CMD_A, CMD_B, ALU_A, ALU_B, ALU_OUT, RSP_DATA;
  logic          Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic [4:0]    RSP_FLAGS;
  logic [CW-1:0] OP_COUNT;

  int           n_tests, n_fail, exp_count;
  logic [3:0]   m_fun;
  logic [W-1:0] m_a, m_b;
  logic [4:0]   flag_flip;
  logic [W+4:0] pipe [LAT];

  alu_cmd_driver #(.WIDTH(W), .ALU_LAT(LAT), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_FUN(CMD_FUN),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .Carry_Flag(Carry_Flag), .Arith_Flag(Arith_Flag),
    .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_FLAGS(RSP_FLAGS),
    .RSP_ERR(RSP_ERR), .BUSY(BUSY), .OP_COUNT(OP_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU behaviour: returns {Shift, CMP, Logic, Arith, Carry, result}.
  function automatic logic [W+4:0] alu_calc(input logic [3:0] fun, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic [4:0]   f;
    s = '0;
    r = '0;
    f = '0;
    case (fun)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; f = {4'b0001, s[W]}; end
      4'h1: begin r = a - b; f = 5'b00010; end
      4'h2: begin r = a * b; f = 5'b00010; end
      4'h3: begin r = (b == '0) ? '0 : a / b; f = 5'b00010; end
      4'h4: begin r = a & b; f = 5'b00100; end
      4'h5: begin r = a | b; f = 5'b00100; end
      4'h6: begin r = ~(a & b); f = 5'b00100; end
      4'h7: begin r = ~(a | b); f = 5'b00100; end
      4'h8: begin r = a ^ b; f = 5'b00100; end
      4'h9: begin r = ~(a ^ b); f = 5'b00100; end
      4'hA: begin r = (a == b) ? W'(1) : '0; f = 5'b01000; end
      4'hB: begin r = (a > b) ? W'(2) : '0; f = 5'b01000; end
      4'hC: begin r = (a < b) ? W'(3) : '0; f = 5'b01000; end
      4'hD: begin r = a >> 1; f = 5'b10000; end
      4'hE: begin r = a << 1; f = 5'b10000; end
      default: begin r = '0; f = '0; end
    endcase
    return {f, r};
  endfunction

  // Exactly the opcode's own group flag must be set among {Shift, CMP, Logic, Arith}.
  function automatic logic exp_err(input logic [3:0] fun, input logic [4:0] flags);
    int g;
    if (fun <= 4'd3) g = 0;
    else if (fun <= 4'd9) g = 1;
    else if (fun <= 4'd12) g = 2;
    else g = 3;
    return flags[4:1] != 4'(1 << g);
  endfunction

  always_ff @(posedge CLK) pipe[0] <= alu_calc(ALU_FUN, ALU_A, ALU_B) ^ {flag_flip, {W{1'b0}}};
  for (genvar g = 1; g < LAT; g++) begin : g_pipe
    always_ff @(posedge CLK) pipe[g] <= pipe[g-1];
  end
  assign ALU_OUT = pipe[LAT-1][W-1:0];
  assign {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag, Carry_Flag} = pipe[LAT-1][W+4:W];

  task automatic rand_cmd_inputs();
    CMD_VALID = 1'($urandom_range(0, 1));
    CMD_FUN   = 4'($urandom);
    CMD_A     = 16'($urandom);
    CMD_B     = 16'($urandom);
  endtask

  // One full transaction; entered and left at a negedge so calls chain back to back.
  task automatic do_txn(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] flip, input int hold, input string tag,
                        output logic [W-1:0] got_data, output logic [4:0] got_flags,
                        output logic got_err);
    logic         direct;
    logic [W+4:0] ref_v;
    logic [W-1:0] e_data;
    logic [4:0]   e_flags;
    logic         e_err;
    int           n, e_lat;
    direct = (fun == 4'hF);
`ifdef ALU_DRV_DIV0_TRAP_EN
    if (fun == 4'h3 && b == '0) direct = 1'b1;
`endif
    ref_v   = alu_calc(fun, a, b) ^ {flip, {W{1'b0}}};
    e_data  = direct ? '0 : ref_v[W-1:0];
    e_flags = direct ? '0 : ref_v[W+4:W];
    e_err   = direct ? 1'b1 : exp_err(fun, e_flags);
    // Edges after the handshake edge until RSP_VALID is seen.
    e_lat   = direct ? 0 : int'(LAT) + 1;
    got_data  = '0;
    got_flags = '0;
    got_err   = 1'b0;

    n_tests++;
    if (CMD_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cmd_ready_idle: got %b want 1", tag, CMD_READY);
    end
    flag_flip = flip;
    CMD_VALID = 1'b1;
    CMD_FUN   = fun;
    CMD_A     = a;
    CMD_B     = b;
    @(posedge CLK);
    if (!direct) begin
      m_fun = fun;
      m_a   = a;
      m_b   = b;
    end
    @(negedge CLK);
    rand_cmd_inputs();
    n = 0;
    while (RSP_VALID !== 1'b1 && n < 20) begin
      n_tests++;
      if (CMD_READY !== 1'b0 || BUSY !== 1'b1 || {ALU_FUN, ALU_A, ALU_B} !== {m_fun, m_a, m_b}) begin
        n_fail++;
        $display("FAIL %s wait: ready %b busy %b alu %h/%h/%h want 0 1 %h/%h/%h", tag, CMD_READY,
                 BUSY, ALU_FUN, ALU_A, ALU_B, m_fun, m_a, m_b);
      end
      RSP_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      n++;
      rand_cmd_inputs();
    end
    RSP_READY = 1'b0;
    n_tests++;
    if (n != e_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, n, e_lat);
    end
    if (RSP_VALID !== 1'b1) begin
      CMD_VALID = 1'b0;
      return;
    end
    got_data  = RSP_DATA;
    got_flags = RSP_FLAGS;
    got_err   = RSP_ERR;
    n_tests++;
    if ({RSP_DATA, RSP_FLAGS, RSP_ERR} !== {e_data, e_flags, e_err}) begin
      n_fail++;
      $display("FAIL %s rsp: got %h/%b/%b want %h/%b/%b", tag, RSP_DATA, RSP_FLAGS, RSP_ERR,
               e_data, e_flags, e_err);
    end
    n_tests++;
    if ({ALU_FUN, ALU_A, ALU_B} !== {m_fun, m_a, m_b}) begin
      n_fail++;
      $display("FAIL %s alu_hold: got %h/%h/%h want %h/%h/%h", tag, ALU_FUN, ALU_A, ALU_B,
               m_fun, m_a, m_b);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      n_tests++;
      if (RSP_VALID !== 1'b1 || CMD_READY !== 1'b0 ||
          {RSP_DATA, RSP_FLAGS, RSP_ERR} !== {e_data, e_flags, e_err}) begin
        n_fail++;
        $display("FAIL %s backpressure: valid %b ready %b rsp %h/%b/%b want 1 0 %h/%b/%b", tag,
                 RSP_VALID, CMD_READY, RSP_DATA, RSP_FLAGS, RSP_ERR, e_data, e_flags, e_err);
      end
      rand_cmd_inputs();
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    exp_count = (exp_count + 1) % (1 << CW);
    @(negedge CLK);
    RSP_READY = 1'b0;
    CMD_VALID = 1'b0;
    n_tests++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1 || BUSY !== 1'b0 || OP_COUNT !== CW'(exp_count)) begin
      n_fail++;
      $display("FAIL %s after_hs: valid %b ready %b busy %b count %0d want 0 1 0 %0d", tag,
               RSP_VALID, CMD_READY, BUSY, OP_COUNT, exp_count);
    end
  endtask

  task automatic test_reset();
    RST       = 1'b0;
    CMD_VALID = 1'b0;
    RSP_READY = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST       = 1'b1;
    exp_count = 0;
    m_fun     = '0;
    m_a       = '0;
    m_b       = '0;
    n_tests++;
    if ({CMD_READY, BUSY, RSP_VALID, RSP_ERR, RSP_FLAGS} !== 9'b1_0000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 100000000", {CMD_READY, BUSY, RSP_VALID, RSP_ERR,
               RSP_FLAGS});
    end
    n_tests++;
    if ({RSP_DATA, ALU_A, ALU_B, ALU_FUN, OP_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h %h want all 0", RSP_DATA, ALU_A, ALU_B, ALU_FUN,
               OP_COUNT);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] d;
    logic [4:0]   f;
    logic         e;
    do_txn(4'h0, 16'd6, 16'd7, 5'b0, 0, "add", d, f, e);
    n_tests++;
    if (d !== 16'd13 || f[1] !== 1'b1 || e !== 1'b0 || OP_COUNT !== CW'(1)) begin
      n_fail++;
      $display("FAIL add_directed: got %0d/%b/%b/%0d want 13/arith=1/0/1", d, f, e, OP_COUNT);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    logic [4:0]   f;
    logic         e;
    do_txn(4'hB, 16'h000F, 16'h000A, 5'b0, 5, "cmp_gt_bp", d, f, e);
    n_tests++;
    if (d !== 16'd2 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL cmp_gt_directed: got %0d/%b want 2/0", d, e);
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] d;
    logic [4:0]   f;
    logic         e;
    do_txn(4'h8, 16'h1234, 16'h00FF, 5'b0, 1, "xor_pre", d, f, e);
    do_txn(4'hF, 16'hBEEF, 16'hCAFE, 5'b0, 2, "illegal", d, f, e);
    n_tests++;
    if (d !== '0 || f !== '0 || e !== 1'b1 || ALU_FUN !== 4'h8 || ALU_A !== 16'h1234) begin
      n_fail++;
      $display("FAIL illegal_directed: got %h/%b/%b fun %h a %h want 0/0/1 fun 8 a 1234", d, f, e,
               ALU_FUN, ALU_A);
    end
  endtask

  task automatic test_div0();
    logic [W-1:0] d;
    logic [4:0]   f;
    logic         e, e_want;
`ifdef ALU_DRV_DIV0_TRAP_EN
    e_want = 1'b1;
`else
    e_want = 1'b0;
`endif
    do_txn(4'h3, 16'd14, 16'd0, 5'b0, 0, "div0", d, f, e);
    n_tests++;
    if (d !== '0 || e !== e_want) begin
      n_fail++;
      $display("FAIL div0_directed: got %h/%b want 0/%b", d, e, e_want);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [W-1:0] d;
    logic [4:0]   f;
    logic         e;
    flag_flip = '0;
    CMD_VALID = 1'b1;
    CMD_FUN   = 4'h8;
    CMD_A     = 16'hAAAA;
    CMD_B     = 16'h5555;
    @(posedge CLK);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    n_tests++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_accept: busy got %b want 1", BUSY);
    end
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST       = 1'b1;
    exp_count = 0;
    m_fun     = '0;
    m_a       = '0;
    m_b       = '0;
    n_tests++;
    if ({CMD_READY, BUSY, RSP_VALID, RSP_ERR, RSP_FLAGS} !== 9'b1_0000_0000 ||
        {RSP_DATA, ALU_A, ALU_B, ALU_FUN, OP_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: ctrl %b data %h alu %h/%h/%h cnt %0d want 100000000 all 0",
               {CMD_READY, BUSY, RSP_VALID, RSP_ERR, RSP_FLAGS}, RSP_DATA, ALU_FUN, ALU_A, ALU_B,
               OP_COUNT);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_tests++;
      if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_wait_no_rsp: valid %b ready %b want 0 1", RSP_VALID, CMD_READY);
      end
    end
    do_txn(4'hD, 16'd14, 16'($urandom), 5'b0, 0, "shr", d, f, e);
    n_tests++;
    if (d !== 16'd7) begin
      n_fail++;
      $display("FAIL shr_directed: got %0d want 7", d);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic [4:0]   f;
    logic         e;
    logic [3:0]   fun;
    logic [W-1:0] a, b;
    logic [4:0]   flip;
    for (int i = 0; i < 40; i++) begin
      fun  = 4'($urandom_range(0, 15));
      a    = 16'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? '0 : 16'($urandom);
      flip = ($urandom_range(0, 7) < 5) ? 5'b0 : 5'(1 << $urandom_range(0, 4));
      do_txn(fun, a, b, flip, $urandom_range(0, 3), "random", d, f, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic [4:0]   f;
    logic         e;
    test_reset();
    for (int i = 1; i <= 17; i++) begin
      do_txn(4'hE, 16'd6, 16'($urandom), 5'b0, 0, "shl_b2b", d, f, e);
      n_tests++;
      if (d !== 16'd12) begin
        n_fail++;
        $display("FAIL shl_b2b_data: got %0d want 12 (op %0d)", d, i);
      end
      if (i == 16 || i == 17) begin
        n_tests++;
        if (OP_COUNT !== CW'(i - 16)) begin
          n_fail++;
          $display("FAIL count_wrap: got %0d want %0d (op %0d)", OP_COUNT, i - 16, i);
        end
      end
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_count = 0;
    RST       = 1'b0;
    CMD_VALID = 1'b0;
    CMD_FUN   = '0;
    CMD_A     = '0;
    CMD_B     = '0;
    RSP_READY = 1'b0;
    flag_flip = '0;
    m_fun     = '0;
    m_a       = '0;
    m_b       = '0;
    test_reset();
    test_add();
    test_backpressure();
    test_illegal();
    test_div0();
    test_reset_in_wait();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Command-side master for the 16-bit clocked ALU.
- Accepts one operation at a time (opcode, A, B) over a valid/ready command channel and drives the ALU operand/function inputs.
- Waits the ALU pipeline latency, then captures ALU_OUT and the five flags and returns them on a valid/ready response channel.
- Sits between the control sequencer and the ALU; also checks flag consistency and counts completed operations.

Parameters:
WIDTH, 16, operand/result width; must match the ALU.
ALU_LAT, 1, ALU input-to-output latency in CLK cycles; legal range 1..7.
CNT_W, 16, width of the completed-operation counter.

Ports:
CLK  in  1  clock, all logic rising-edge.
RST  in  1  synchronous reset, active-low.
CMD_VALID  in  1  command present.
CMD_READY  out  1  driver can accept a command.
CMD_FUN  in  4  ALU opcode (0000 ADD .. 1110 SHL; 1111 unused).
CMD_A  in  WIDTH  operand A.
CMD_B  in  WIDTH  operand B.
ALU_A  out  WIDTH  to ALU A.
ALU_B  out  WIDTH  to ALU B.
ALU_FUN  out  4  to ALU ALU_FUN.
ALU_OUT  in  WIDTH  from ALU result.
Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  from ALU.
RSP_VALID  out  1  response present.
RSP_READY  in  1  consumer accepts response.
RSP_DATA  out  WIDTH  captured ALU result.
RSP_FLAGS  out  5  {Shift,CMP,Logic,Arith,Carry} captured.
RSP_ERR  out  1  illegal opcode or flag-group mismatch.
BUSY  out  1  high in any state except IDLE.
OP_COUNT  out  CNT_W  responses completed (handshaken).

Behaviour:
Reset:
- RST sampled low at a CLK edge sends the FSM to IDLE.
- All outputs go to 0 except CMD_READY=1. This includes ALU_A/ALU_B/ALU_FUN=0, RSP_*=0, BUSY=0 and OP_COUNT=0.
- Reset mid-operation discards any in-flight command or pending response with no handshake.

FSM states:
- IDLE: CMD_READY=1.
  - On CMD_VALID&CMD_READY at edge k, latch CMD_FUN/A/B into ALU_FUN/ALU_A/ALU_B.
  - Load the wait counter with ALU_LAT and go to WAIT.
  - If CMD_FUN=1111, do not change the ALU outputs; go directly to RESP with RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=1 (RSP_VALID after edge k).
- WAIT: CMD_READY=0. ALU inputs are held stable. The counter decrements each cycle; at 0 go to CAPTURE.
- CAPTURE: one cycle. At the edge k+ALU_LAT+1, register ALU_OUT into RSP_DATA and the flags into RSP_FLAGS, compute RSP_ERR, set RSP_VALID, and go to RESP.
  - Latency from command handshake to RSP_VALID is ALU_LAT+1 cycles.
- RESP: RSP_VALID=1. RSP_DATA/FLAGS/ERR are held until RSP_READY.
  - On RSP_VALID&RSP_READY: clear RSP_VALID, increment OP_COUNT, return to IDLE (CMD_READY=1 the next cycle).
  - RSP_READY held high still costs one cycle in RESP.

Flag check:
- Expected group by opcode: 0000-0011 Arith, 0100-1001 Logic, 1010-1100 CMP, 1101-1110 Shift.
- RSP_ERR=1 if the captured expected-group flag is 0, or any other group flag among Arith/Logic/CMP/Shift is 1.
- Carry_Flag is excluded from the check.

OP_COUNT:
- Wraps from 2^CNT_W-1 to 0 with no saturation.
- Increments on every response handshake, including error responses.

Inputs:
- CMD_* values outside IDLE are ignored.
- RSP_READY outside RESP is ignored.
- ALU_A/ALU_B/ALU_FUN keep the last issued values in IDLE.

Optional Feature:
ALU_DRV_DIV0_TRAP_EN
- Defined: a command with CMD_FUN=0011 and CMD_B=0 is not issued to the ALU, and the ALU outputs are unchanged.
  - Go IDLE->RESP directly with RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=1; RSP_VALID one cycle after the handshake.
- Undefined: the command is issued normally and the ALU's own result is returned (ALU returns 0). RSP_ERR comes only from the flag check (0 for a correct ALU).

Test Plan:
- ADD: A=6, B=7, FUN=0000, ALU_LAT=1 -> RSP_VALID 2 cycles after the handshake; RSP_DATA=13, Arith_Flag bit=1, RSP_ERR=0, OP_COUNT=1.
- Backpressure: CMP greater, A=0x000F, B=0x000A, FUN=1011, RSP_READY low 5 cycles -> RSP_DATA=2 held stable, CMD_READY=0 throughout; after the handshake OP_COUNT increments and CMD_READY=1 the next cycle.
- Illegal opcode: FUN=1111 -> RSP_ERR=1, RSP_DATA=0, ALU_FUN unchanged from the previous command.
- Div by zero: A=14, B=0, FUN=0011 -> with the macro: RSP_ERR=1, RSP_DATA=0, 1-cycle latency. Without the macro: RSP_DATA=0, RSP_ERR=0, latency ALU_LAT+1.
- Reset in WAIT: XOR A=0xAAAA, B=0x5555, RST low 1 cycle during WAIT -> no response, all outputs 0, CMD_READY=1; the next SHR A=14 returns 7.
- Counter wrap: CNT_W=4, 17 back-to-back SHL A=6 commands -> each RSP_DATA=12, OP_COUNT reads 0 after the 16th and 1 after the 17th.
